// File: rtl/ras_ckpt_stack.sv
// Return-address stack with circular storage, call/return swap and a compact
// checkpoint {cnt, ptr, top}. A checkpoint restore rewrites the top entry, which
// repairs a slot that was overwritten on a mispredicted path.
module ras_ckpt_stack #(
  parameter  int DEPTH  = 2,
  parameter  int VLEN   = 64,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int CKPT_W = CW + PW + VLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [VLEN-1:0]   data_i,
  output logic [VLEN-1:0]   data_o,
  output logic              valid_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic [CKPT_W-1:0] ckpt_o,
  input  logic              restore_i,
  input  logic [CKPT_W-1:0] restore_ckpt_i
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [VLEN-1:0] stack_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  // single entry write port shared by push, swap and restore
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [VLEN-1:0] wr_data;

  logic [CW-1:0]   rc_cnt;
  logic [PW-1:0]   rc_ptr;
  logic [VLEN-1:0] rc_top;

  assign rc_cnt = restore_ckpt_i[CKPT_W-1 -: CW];
  assign rc_ptr = restore_ckpt_i[VLEN +: PW];
  assign rc_top = restore_ckpt_i[VLEN-1:0];

  assign data_o      = stack_q[ptr_q];
  assign valid_o     = (cnt_q != '0);
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign ckpt_o      = {cnt_q, ptr_q, stack_q[ptr_q]};

  // next-state: flush > restore > push/pop; pulses only from push/pop decisions
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = data_i;
    if (flush_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (restore_i) begin
      // an out-of-range count can only come from a corrupt checkpoint; clamp it
      cnt_d   = (rc_cnt > FULL) ? FULL : rc_cnt;
      ptr_d   = rc_ptr;
      wr_en   = 1'b1;
      wr_idx  = rc_ptr;
      wr_data = rc_top;
    end else if (push_i && pop_i) begin
      // call-return swap: replace top in place
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = CW'(1);
    end else if (push_i) begin
      ptr_d  = ptr_q + PW'(1);
      wr_en  = 1'b1;
      wr_idx = ptr_q + PW'(1);
      if (cnt_q == FULL) ovf_d = 1'b1;
      else               cnt_d = cnt_q + CW'(1);
    end else if (pop_i) begin
      if (cnt_q != '0) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  // control registers and registered event pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // entry storage: cleared on reset, otherwise at most one write per cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (wr_en) begin
      stack_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: doc/ras_ckpt_stack.md
Name: ras_ckpt_stack

Overview:
Parametrised return-address stack for the frontend branch predictor. It generalises the fixed RAS depth to any power-of-two depth. It stores entries in a circular buffer that overwrites the oldest entry on overflow, handles simultaneous push+pop (call-return swap), and exposes a compact checkpoint that the frontend snapshots per predicted branch. On mispredict, the frontend restores the stack from that checkpoint, which repairs the top entry.

Parameters:
DEPTH, 2, number of entries; power of two, >= 2
VLEN, 64, return-address width in bits
PW (derived), $clog2(DEPTH), top-pointer width
CW (derived), $clog2(DEPTH+1), occupancy-counter width
CKPT_W (derived), CW+PW+VLEN, checkpoint width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  empty the stack (pointer and count only)
push_i  in  1  push data_i (call)
pop_i  in  1  pop top (return)
data_i  in  VLEN  address to push
data_o  out  VLEN  current top entry
valid_o  out  1  stack non-empty
overflow_o  out  1  one-cycle pulse: push dropped the oldest entry
underflow_o  out  1  one-cycle pulse: pop on empty stack
ckpt_o  out  CKPT_W  {cnt, ptr, stack[ptr]}, combinational
restore_i  in  1  load state from restore_ckpt_i
restore_ckpt_i  in  CKPT_W  checkpoint previously taken from ckpt_o

Behaviour:
- State: stack[DEPTH] of VLEN, ptr (PW bits), cnt (0..DEPTH). All updates on the rising edge of clk_i.
- Outputs: data_o = stack[ptr]; valid_o = (cnt != 0); ckpt_o as above. All are combinational from registers, so there is zero-cycle read latency.
- Priority per cycle: rst_i > flush_i > restore_i > push/pop. Lower-priority requests in the same cycle are ignored, and they produce no overflow or underflow pulse.
- Reset: ptr=0, cnt=0, all entries=0. After reset, data_o=0, valid_o=0, overflow_o=0, underflow_o=0, ckpt_o=0.
- Flush: ptr=0, cnt=0. Entries are not cleared. Pulses are 0.
- Restore: {cnt, ptr, top} = restore_ckpt_i, and stack[ckpt ptr] <= ckpt top, which repairs a top entry overwritten after the snapshot. Other entries are untouched.
- Push only: ptr <= ptr+1 (mod DEPTH) and stack[ptr+1] <= data_i.
  - If cnt < DEPTH: cnt <= cnt+1.
  - If cnt == DEPTH: cnt is held, and overflow_o=1 on the next cycle (registered pulse).
- Pop only:
  - If cnt > 0: ptr <= ptr-1 (mod DEPTH) and cnt <= cnt-1.
  - If cnt == 0: no state change, and underflow_o=1 on the next cycle (registered pulse).
- Push and pop together: stack[ptr] <= data_i and ptr is unchanged.
  - cnt is unchanged, except that cnt==0 becomes 1.
  - No overflow or underflow pulse.
- Idle: state is held. overflow_o and underflow_o return to 0 one cycle after their event.
- Pointer arithmetic wraps modulo DEPTH via natural PW-bit overflow. cnt saturates at DEPTH and never goes below 0.
- A restore value with cnt > DEPTH is illegal input. The block clamps cnt to DEPTH.
- All entry writes are single-port: at most one entry is written per cycle.

Test Plan:
- Reset, then check outputs: DEPTH=4, VLEN=64. Assert rst_i for 2 cycles -> valid_o=0, data_o=0, ckpt_o=0, both pulses 0.
- Fill and overflow: push 0x1000, 0x1004, 0x1008, 0x100C, 0x1010 on consecutive cycles.
  - After the 4th push: cnt=4, no overflow.
  - After the 5th push: data_o=0x1010 and overflow_o pulses for exactly 1 cycle.
  - Then pop 4 times -> data_o reads 0x100C, 0x1008, 0x1004, then valid_o=0 (0x1000 was lost).
- Underflow: on an empty stack, pop_i=1 -> underflow_o=1 for one cycle, valid_o stays 0, ptr unchanged.
- Swap: push 0xA0, then push_i=pop_i=1 with 0xB0 -> data_o=0xB0 and cnt stays 1. Pop -> valid_o=0.
- Checkpoint repair: push 0x200, 0x300 and capture ckpt_o. Then pop, then push 0x999 (overwrites 0x300's slot). Then assert restore_i with the saved ckpt -> data_o=0x300 and cnt=2. Pop -> data_o=0x200.
- Priority: flush_i, restore_i and push_i all high in the same cycle -> valid_o=0, cnt=0, no pulse. Next push 0x44 -> data_o=0x44 and valid_o=1.
